// File: rtl/lorenz_sample_decimator.sv
// Decimates the Lorenz integrator's x/y/z stream, saturates each coordinate to OUT_W bits,
// and buffers the kept samples in a first-word-fall-through FIFO with a valid/ready output.
module lorenz_sample_decimator #(
    parameter int DECIM = 10,
    parameter int DEPTH = 8,
    parameter int OUT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [31:0]              in_x,
    input  logic [31:0]              in_y,
    input  logic [31:0]              in_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_x,
    output logic [OUT_W-1:0]         out_y,
    output logic [OUT_W-1:0]         out_z,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic                     sat_flag
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [31:0] MAXV = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    localparam logic signed [31:0] MINV = -(32'sd1 <<< (OUT_W - 1));

    logic [DCW-1:0]   dcnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OUT_W-1:0] mem_x [DEPTH];
    logic [OUT_W-1:0] mem_y [DEPTH];
    logic [OUT_W-1:0] mem_z [DEPTH];

    logic             dcnt_last;
    logic             capture;
    logic             full;
    logic             pop;
    logic             push;
    logic [OUT_W:0]   sx;
    logic [OUT_W:0]   sy;
    logic [OUT_W:0]   sz;
    logic [AW:0]      fill_next;

    // Returns {saturated, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [31:0] v);
        if (v > MAXV)
            return {1'b1, MAXV[OUT_W-1:0]};
        else if (v < MINV)
            return {1'b1, MINV[OUT_W-1:0]};
        else
            return {1'b0, v[OUT_W-1:0]};
    endfunction

    always_comb begin
        sx = saturate(in_x);
        sy = saturate(in_y);
        sz = saturate(in_z);
    end

    assign dcnt_last = (dcnt == DCW'(DECIM - 1));
    assign capture   = enable && in_valid && dcnt_last;
    assign full      = (fill == (AW + 1)'(DEPTH));
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push      = capture && (!full || pop);

    always_comb begin
        fill_next = fill;
        case ({push, pop})
            2'b10:   fill_next = fill + 1'b1;
            2'b01:   fill_next = fill - 1'b1;
            default: fill_next = fill;
        endcase
    end

    assign out_x = out_valid ? mem_x[rd_ptr] : '0;
    assign out_y = out_valid ? mem_y[rd_ptr] : '0;
    assign out_z = out_valid ? mem_z[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
            sat_flag <= 1'b0;
        end else if (clear) begin
            dcnt     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (enable && in_valid)
                dcnt <= dcnt_last ? '0 : dcnt + 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (sx[OUT_W] || sy[OUT_W] || sz[OUT_W])
                    sat_flag <= 1'b1;
            end
            if (capture && !push)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fill <= fill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_x[wr_ptr] <= sx[OUT_W-1:0];
            mem_y[wr_ptr] <= sy[OUT_W-1:0];
            mem_z[wr_ptr] <= sz[OUT_W-1:0];
        end
    end

endmodule

// File: tb/tb_lorenz_sample_decimator.sv
// Drives a DECIM=10 and a DECIM=1 decimator from shared stimulus and checks both every cycle
// against a queue-based model, plus directed literal checks of latency, saturation and flow control.
module tb_lorenz_sample_decimator;

    localparam int DEPTH = 8;
    localparam int OUT_W = 16;
    localparam int FW    = $clog2(DEPTH) + 1;
    localparam int DEC [2] = '{10, 1};

    typedef struct {
        longint x;
        longint y;
        longint z;
    } samp_t;

    logic              clk;
    logic              reset_n;
    logic              en, clr, iv, ordy;
    logic [31:0]       ix, iy, iz;
    logic [1:0]        ov, ovf, sf;
    logic signed [OUT_W-1:0] ox [2];
    logic signed [OUT_W-1:0] oy [2];
    logic signed [OUT_W-1:0] oz [2];
    logic [FW-1:0]     fl [2];

    int     n_tests = 0;
    int     n_fail  = 0;
    samp_t  mq [2][$];
    longint mcnt [2];
    bit     movf [2];
    bit     msat [2];
    longint lg [2][$];
    bit     log_en;
    int     fmax0;
    int     found;

    lorenz_sample_decimator #(.DECIM(10), .DEPTH(DEPTH), .OUT_W(OUT_W)) u_d10 (
        .clk(clk), .reset_n(reset_n), .enable(en), .clear(clr), .in_valid(iv),
        .in_x(ix), .in_y(iy), .in_z(iz), .out_valid(ov[0]), .out_ready(ordy),
        .out_x(ox[0]), .out_y(oy[0]), .out_z(oz[0]), .fill(fl[0]),
        .overflow(ovf[0]), .sat_flag(sf[0])
    );

    lorenz_sample_decimator #(.DECIM(1), .DEPTH(DEPTH), .OUT_W(OUT_W)) u_d1 (
        .clk(clk), .reset_n(reset_n), .enable(en), .clear(clr), .in_valid(iv),
        .in_x(ix), .in_y(iy), .in_z(iz), .out_valid(ov[1]), .out_ready(ordy),
        .out_x(ox[1]), .out_y(oy[1]), .out_z(oz[1]), .fill(fl[1]),
        .overflow(ovf[1]), .sat_flag(sf[1])
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint satm(input longint v, output bit s);
        longint hi, lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        s = 1'b1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        s = 1'b0;
        return v;
    endfunction

    // Model: every DEC-th qualifying sample is kept; head leaves before the new sample arrives.
    always @(posedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                bit    cap, pop, s0, s1, s2;
                samp_t smp;
                if (clr) begin
                    mq[d].delete();
                    mcnt[d] = 0;
                    movf[d] = 0;
                    msat[d] = 0;
                end else begin
                    cap = 0;
                    if (en && iv) begin
                        mcnt[d]++;
                        cap = (mcnt[d] % DEC[d] == 0);
                    end
                    pop = (mq[d].size() > 0) && ordy;
                    if (pop) void'(mq[d].pop_front());
                    if (cap) begin
                        if (mq[d].size() < DEPTH) begin
                            smp.x = satm(longint'($signed(ix)), s0);
                            smp.y = satm(longint'($signed(iy)), s1);
                            smp.z = satm(longint'($signed(iz)), s2);
                            mq[d].push_back(smp);
                            if (s0 || s1 || s2) msat[d] = 1;
                        end else begin
                            movf[d] = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge reset_n) begin
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            mcnt[d] = 0;
            movf[d] = 0;
            msat[d] = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_out_valid", d), ov[d], mq[d].size() > 0);
                chk($sformatf("d%0d_fill", d), fl[d], mq[d].size());
                chk($sformatf("d%0d_overflow", d), ovf[d], movf[d]);
                chk($sformatf("d%0d_sat_flag", d), sf[d], msat[d]);
                if (mq[d].size() > 0) begin
                    chk($sformatf("d%0d_head_x", d), ox[d], mq[d][0].x);
                    chk($sformatf("d%0d_head_y", d), oy[d], mq[d][0].y);
                    chk($sformatf("d%0d_head_z", d), oz[d], mq[d][0].z);
                end
                if (log_en && ov[d] && ordy) lg[d].push_back(ox[d]);
            end
            if (int'(fl[0]) > fmax0) fmax0 = int'(fl[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1;
        cyc();
        clr = 0;
    endtask

    initial begin
        reset_n = 0; en = 0; clr = 0; iv = 0; ordy = 0;
        ix = 0; iy = 0; iz = 0; log_en = 0; fmax0 = 0;

        // Reset with random inputs
        repeat (5) begin
            cyc();
            en = 1'($urandom); clr = 1'($urandom); iv = 1'($urandom); ordy = 1'($urandom);
            ix = $urandom; iy = $urandom; iz = $urandom;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_d%0d_valid", d), ov[d], 0);
            chk($sformatf("rst_d%0d_fill", d), fl[d], 0);
            chk($sformatf("rst_d%0d_overflow", d), ovf[d], 0);
            chk($sformatf("rst_d%0d_sat", d), sf[d], 0);
            chk($sformatf("rst_d%0d_out_x", d), ox[d], 0);
            chk($sformatf("rst_d%0d_out_z", d), oz[d], 0);
        end

        // First kept sample after release
        en = 1; clr = 0; iv = 1; ordy = 0; ix = 100; iy = 200; iz = 300;
        reset_n = 1;
        found = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (ov[0]) begin found = c; break; end
        end
        chk("first_valid_latency", found, 10);
        chk("first_head_x", ox[0], 100);
        chk("first_head_y", oy[0], 200);
        chk("first_head_z", oz[0], 300);
        chk("first_fill", fl[0], 1);
        chk("d1_full_fill", fl[1], 8);
        chk("d1_full_overflow", ovf[1], 1);

        // Decimation stride with a ramp
        do_clear();
        ordy = 1; fmax0 = 0; lg[0].delete(); log_en = 1;
        for (int k = 0; k < 60; k++) begin
            ix = k;
            cyc();
        end
        log_en = 0;
        chk("stride_count", lg[0].size(), 5);
        for (int i = 0; i < 5 && i < lg[0].size(); i++)
            chk($sformatf("stride_x%0d", i), lg[0][i], 10 * i + 9);
        chk("stride_fill_max", fmax0, 1);

        // Saturation
        do_clear();
        ordy = 0; ix = 40000; iy = -32'sd40000; iz = -32'sd5;
        found = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (ov[0]) begin found = c; break; end
        end
        chk("sat_latency", found, 10);
        chk("sat_x", ox[0], 32767);
        chk("sat_y", oy[0], -32768);
        chk("sat_z", oz[0], -5);
        chk("sat_flag_set", sf[0], 1);
        ix = 123; iy = -456; iz = 789;
        repeat (10) cyc();
        chk("sat_flag_sticky", sf[0], 1);
        chk("sat_second_fill", fl[0], 2);

        // Overflow with DECIM=1
        do_clear();
        ordy = 0; iy = 0; iz = 0;
        for (int k = 0; k < 12; k++) begin
            ix = k;
            cyc();
        end
        chk("ovf_fill", fl[1], 8);
        chk("ovf_flag", ovf[1], 1);
        chk("ovf_head", ox[1], 0);
        en = 0; ordy = 1; lg[1].delete(); log_en = 1;
        repeat (10) cyc();
        log_en = 0;
        chk("drain_count", lg[1].size(), 8);
        for (int i = 0; i < 8 && i < lg[1].size(); i++)
            chk($sformatf("drain_x%0d", i), lg[1][i], i);

        // Full FIFO with simultaneous push and pop
        do_clear();
        en = 1; ordy = 0;
        for (int k = 0; k < 8; k++) begin
            ix = 100 + k;
            cyc();
        end
        chk("fullpp_fill_pre", fl[1], 8);
        ordy = 1;
        for (int k = 0; k < 6; k++) begin
            ix = 200 + k;
            cyc();
            chk($sformatf("fullpp_fill%0d", k), fl[1], 8);
        end
        chk("fullpp_overflow", ovf[1], 0);
        chk("fullpp_head", ox[1], 106);

        // enable low for 5 cycles mid-count
        do_clear();
        ordy = 0; found = 0;
        for (int k = 0; k < 20; k++) begin
            ix = k;
            en = !(k >= 4 && k < 9);
            cyc();
            if (ov[0] && found == 0) found = k + 1;
        end
        en = 1;
        chk("enable_latency", found, 15);
        chk("enable_head_x", ox[0], 14);

        // clear coincident with capture and pop
        do_clear();
        en = 1; ordy = 0; ix = 40000;
        repeat (3) cyc();
        chk("clr_pre_fill", fl[1], 3);
        chk("clr_pre_sat", sf[1], 1);
        clr = 1; ordy = 1;
        cyc();
        clr = 0; ordy = 0; ix = 7;
        chk("clr_fill", fl[1], 0);
        chk("clr_valid", ov[1], 0);
        chk("clr_overflow", ovf[1], 0);
        chk("clr_sat", sf[1], 0);
        found = 0;
        for (int c = 1; c <= 20; c++) begin
            if (ov[0]) begin found = c; break; end
            cyc();
        end
        chk("clr_dcnt_latency", found, 11);

        // Async reset between edges
        do_clear();
        en = 1; ordy = 0; ix = 5;
        repeat (5) cyc();
        chk("arst_pre_fill", fl[1], 5);
        #2;
        reset_n = 0;
        #1;
        chk("arst_fill", fl[1], 0);
        chk("arst_valid", ov[1], 0);
        chk("arst_out_x", ox[1], 0);
        #20;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lorenz_sample_decimator.md
Name: lorenz_sample_decimator

Overview:
- Downstream stage of the Lorenz integrator. Consumes the integrator's x/y/z state, which updates every clock in x100 fixed point.
- Keeps every DECIM-th sample and saturates each coordinate to a signed OUT_W-bit word.
- Buffers samples in a DEPTH-entry FIFO and presents them to the reservoir input layer over a valid/ready handshake.

Parameters:
- DECIM, 10, input samples per kept sample (>=1; 1 keeps every sample).
- DEPTH, 8, FIFO entries (power of two, >=2).
- OUT_W, 16, width of each output coordinate, signed two's complement.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  sampling enable; low freezes the decimation counter.
- clear  input  1  synchronous flush; see Behaviour.
- in_valid  input  1  input sample valid; tie high when the integrator free-runs.
- in_x  input  32  integrator x, signed two's complement, x100.
- in_y  input  32  integrator y, signed two's complement, x100.
- in_z  input  32  integrator z, signed two's complement, x100.
- out_valid  output  1  FIFO head valid (FIFO non-empty).
- out_ready  input  1  consumer accepts the head this cycle.
- out_x  output  OUT_W  head x, saturated.
- out_y  output  OUT_W  head y, saturated.
- out_z  output  OUT_W  head z, saturated.
- fill  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a kept sample was dropped because the FIFO was full.
- sat_flag  output  1  sticky: at least one stored coordinate was saturated.

Behaviour:

Reset:
- reset_n low forces, asynchronously:
  - decimation counter = 0
  - FIFO pointers = 0, fill = 0, out_valid = 0
  - out_x/out_y/out_z = 0
  - overflow = 0, sat_flag = 0

Decimation:
- Counter dcnt counts 0..DECIM-1 and advances only on cycles with enable && in_valid.
- A capture occurs on such a cycle when dcnt == DECIM-1; dcnt then wraps to 0.
- With DECIM=1 every valid, enabled cycle is a capture.

Saturation:
- Each coordinate is evaluated independently, combinationally, at capture.
- Value > 2^(OUT_W-1)-1 stores 2^(OUT_W-1)-1.
- Value < -2^(OUT_W-1) stores -2^(OUT_W-1).
- Otherwise the low OUT_W bits are stored unchanged.
- Any saturated coordinate in a sample that is actually written sets sat_flag.

FIFO:
- Synchronous, first-word-fall-through.
- out_x/out_y/out_z always reflect the head entry while out_valid = 1. Outputs are registered, or read combinationally from registers; either way they are glitch-free at the clock edge.
- Push = capture. Pop = out_valid && out_ready.
- Capture-to-out_valid latency into an empty FIFO is 1 cycle: data is visible the cycle after the capture edge.
- Full, push, no pop: the sample is dropped, overflow sets, the FIFO is unchanged and sat_flag is not updated.
- Full, push and pop on the same cycle: both succeed and fill stays at DEPTH.
- Empty, push and pop on the same cycle: the pop is ignored (out_valid = 0) and the push succeeds.
- Pointers wrap modulo DEPTH. fill is exact at every cycle.

clear (synchronous, highest priority below reset):
- Resets dcnt, both pointers, fill, overflow and sat_flag.
- Any capture or pop on that cycle is discarded.
- out_valid is 0 on the following cycle.

enable low:
- Blocks capture and holds dcnt.
- The pop side continues normally, so the FIFO can drain.

Reset mid-transfer:
- Contents are lost.
- The consumer must ignore any handshake in progress when reset_n asserts.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> out_valid=0, fill=0, overflow=0, sat_flag=0, outputs 0; release, DECIM=10, in_valid=1, enable=1, in_x=100, in_y=200, in_z=300, out_ready=0 -> first out_valid=1 exactly 10 cycles after release, head=(100,200,300), fill=1.
- Decimation stride: ramp in_x=k on cycle k, DECIM=10, out_ready=1 -> out_x sequence 9,19,29,...; out_valid pulses once per 10 cycles; fill never exceeds 1.
- Saturation: OUT_W=16, in_x=40000, in_y=-40000 (0xFFFF63C0), in_z=-5 -> out=(32767,-32768,-5), sat_flag=1; next sample in range -> sat_flag stays 1 until clear.
- Overflow and full boundary: DECIM=1, DEPTH=8, out_ready=0 for 12 cycles with in_x=0..11 -> fill=8, overflow=1, head 0, draining yields 0..7 only; repeat with full FIFO and out_ready=1 while capturing -> fill holds 8, no overflow, order preserved.
- enable and clear: enable=0 for 5 cycles mid-count (dcnt=4) -> dcnt still 4 afterwards and capture delayed by 5 cycles; with fill=3 assert clear for 1 cycle coincident with a capture and a pop -> next cycle fill=0, out_valid=0, overflow=0, sat_flag=0, dcnt=0.
- Async reset mid-operation: fill=5, assert reset_n=0 between clock edges -> fill=0 and out_valid=0 immediately, without waiting for a clock edge.
